// File: rtl/forward_action_dispatch_pkg.sv
// rtl/forward_action_dispatch_pkg.sv - shared constants and types for the forwarding action dispatcher
package forward_action_dispatch_pkg;

    localparam int PORT_NUM  = 9;
    localparam int CTRL_PORT = 8;

    // Queue descriptor layout: {type, inport, bufid}
    localparam int TYPE_MSB   = 15;
    localparam int TYPE_LSB   = 13;
    localparam int INPORT_MSB = 12;
    localparam int INPORT_LSB = 9;
    localparam int BUFID_MSB  = 8;
    localparam int BUFID_LSB  = 0;

    // Lookup-FIFO entry layout shared with the DMAC lookup stage
    localparam int LKP_WIDTH      = 71;
    localparam int LKP_BUFID_LSB  = 0;
    localparam int LKP_INPORT_LSB = 9;
    localparam int LKP_TYPE_LSB   = 13;
    localparam int LKP_DMAC_LSB   = 16;
    localparam int LKP_META_LSB   = 64;

    typedef enum logic [1:0] {
        DISP_IDLE     = 2'd0,
        DISP_COUNT    = 2'd1,
        DISP_DISPATCH = 2'd2,
        DISP_ACK      = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/forward_action_dispatch_if.sv
// rtl/forward_action_dispatch_if.sv - action request, queue descriptor and buffer-manager signal bundle
interface forward_action_dispatch_if;
    import forward_action_dispatch_pkg::*;

    logic                i_action_req;
    logic [PORT_NUM-1:0] iv_outport;
    logic                i_entry_hit;
    logic [2:0]          iv_pkt_type;
    logic [3:0]          iv_pkt_inport;
    logic [8:0]          iv_pkt_bufid;
    logic                o_action_ack;
    logic                o_desc_wr;
    logic [3:0]          ov_desc_port;
    logic [15:0]         ov_desc_data;
    logic [PORT_NUM-1:0] iv_queue_full;
    logic                o_bufid_cnt_wr;
    logic [8:0]          ov_bufid;
    logic [3:0]          ov_bufid_cnt;
    logic                o_bufid_free_wr;
    logic [15:0]         ov_drop_cnt;
    logic [15:0]         ov_flood_cnt;

    modport slave (
        input  i_action_req, iv_outport, i_entry_hit, iv_pkt_type, iv_pkt_inport,
               iv_pkt_bufid, iv_queue_full,
        output o_action_ack, o_desc_wr, ov_desc_port, ov_desc_data, o_bufid_cnt_wr,
               ov_bufid, ov_bufid_cnt, o_bufid_free_wr, ov_drop_cnt, ov_flood_cnt
    );

    modport master (
        output i_action_req, iv_outport, i_entry_hit, iv_pkt_type, iv_pkt_inport,
               iv_pkt_bufid, iv_queue_full,
        input  o_action_ack, o_desc_wr, ov_desc_port, ov_desc_data, o_bufid_cnt_wr,
               ov_bufid, ov_bufid_cnt, o_bufid_free_wr, ov_drop_cnt, ov_flood_cnt
    );

endinterface

// File: rtl/forward_action_dispatch_port_bitmap_scan.sv
// rtl/forward_action_dispatch_port_bitmap_scan.sv - popcount and lowest-set-bit encoder for the port bitmap
module port_bitmap_scan
    import forward_action_dispatch_pkg::*;
(
    input  logic [PORT_NUM-1:0] bitmap,
    output logic [3:0]          pop_cnt,
    output logic [3:0]          low_idx,
    output logic                low_vld
);

    // Descending scan so the lowest set bit is the last one to win
    always_comb begin
        pop_cnt = 4'd0;
        low_idx = 4'd0;
        low_vld = 1'b0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            pop_cnt = pop_cnt + {3'b000, bitmap[i]};
            if (bitmap[i]) begin
                low_idx = 4'(i);
                low_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/forward_action_dispatch.sv
// rtl/forward_action_dispatch.sv - replicates one forwarding decision into per-queue descriptor writes
module forward_action_dispatch
    import forward_action_dispatch_pkg::*;
(
    input logic                     i_clk,
    input logic                     i_rst_n,
    forward_action_dispatch_if.slave act
);

    localparam logic [1:0] S_IDLE     = DISP_IDLE;
    localparam logic [1:0] S_COUNT    = DISP_COUNT;
    localparam logic [1:0] S_DISPATCH = DISP_DISPATCH;
    localparam logic [1:0] S_ACK      = DISP_ACK;

    logic [1:0]          state;
    logic [PORT_NUM-1:0] bitmap;
    logic [2:0]          pkt_type;
    logic [3:0]          pkt_inport;
    logic [8:0]          pkt_bufid;
    logic                pkt_hit;

    logic                ack;
    logic                desc_wr;
    logic [3:0]          desc_port;
    logic [15:0]         desc_data;
    logic                cnt_wr;
    logic [8:0]          bufid_out;
    logic [3:0]          bufid_cnt;
    logic                free_wr;
    logic [15:0]         drop_cnt;
    logic [15:0]         flood_cnt;

    logic [3:0]          pop_cnt;
    logic [3:0]          low_idx;
    logic                low_vld;
    logic [PORT_NUM-1:0] prune_mask;
    logic [PORT_NUM-1:0] bitmap_nxt;

    port_bitmap_scan u_scan (
        .bitmap  (bitmap),
        .pop_cnt (pop_cnt),
        .low_idx (low_idx),
        .low_vld (low_vld)
    );

    // The packet never goes back out its own Ethernet port; the CPU port is exempt
    always_comb begin
        prune_mask = '1;
        if (act.iv_pkt_inport < 4'(CTRL_PORT)) begin
            prune_mask = ~(PORT_NUM'(1) << act.iv_pkt_inport);
        end
    end

    assign bitmap_nxt = bitmap & ~(PORT_NUM'(1) << low_idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            bitmap     <= '0;
            pkt_type   <= '0;
            pkt_inport <= '0;
            pkt_bufid  <= '0;
            pkt_hit    <= 1'b0;
            ack        <= 1'b0;
            desc_wr    <= 1'b0;
            desc_port  <= '0;
            desc_data  <= '0;
            cnt_wr     <= 1'b0;
            bufid_out  <= '0;
            bufid_cnt  <= '0;
            free_wr    <= 1'b0;
            drop_cnt   <= '0;
            flood_cnt  <= '0;
        end else begin
            ack       <= 1'b0;
            desc_wr   <= 1'b0;
            desc_port <= '0;
            desc_data <= '0;
            cnt_wr    <= 1'b0;
            bufid_out <= '0;
            bufid_cnt <= '0;
            free_wr   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (act.i_action_req) begin
                        bitmap     <= act.iv_outport & prune_mask;
                        pkt_type   <= act.iv_pkt_type;
                        pkt_inport <= act.iv_pkt_inport;
                        pkt_bufid  <= act.iv_pkt_bufid;
                        pkt_hit    <= act.i_entry_hit;
                        state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!pkt_hit && flood_cnt != 16'hFFFF) begin
                        flood_cnt <= flood_cnt + 16'd1;
                    end
                    bufid_out <= pkt_bufid;
                    if (low_vld) begin
                        cnt_wr    <= 1'b1;
                        bufid_cnt <= pop_cnt;
                        state     <= S_DISPATCH;
                    end else begin
                        free_wr <= 1'b1;
                        if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                        state <= S_ACK;
                    end
                end
                S_DISPATCH: begin
                    // A full queue stalls in place so copies stay in ascending port order
                    if (!low_vld) begin
                        state <= S_ACK;
                    end else if (!act.iv_queue_full[low_idx]) begin
                        desc_wr   <= 1'b1;
                        desc_port <= low_idx;
                        desc_data <= {pkt_type, pkt_inport, pkt_bufid};
                        bitmap    <= bitmap_nxt;
                        if (bitmap_nxt == '0) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    ack   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign act.o_action_ack    = ack;
    assign act.o_desc_wr       = desc_wr;
    assign act.ov_desc_port    = desc_port;
    assign act.ov_desc_data    = desc_data;
    assign act.o_bufid_cnt_wr  = cnt_wr;
    assign act.ov_bufid        = bufid_out;
    assign act.ov_bufid_cnt    = bufid_cnt;
    assign act.o_bufid_free_wr = free_wr;
    assign act.ov_drop_cnt     = drop_cnt;
    assign act.ov_flood_cnt    = flood_cnt;

endmodule

// File: tb/tb_forward_action_dispatch.sv
// tb/tb_forward_action_dispatch.sv - directed self-checking bench for forward_action_dispatch
module tb_forward_action_dispatch;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    forward_action_dispatch_if bus ();

    forward_action_dispatch dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .act     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed strobe view: {ack, desc_wr, port, data, cnt_wr, bufid, cnt, free_wr}
    function automatic logic [63:0] obs();
        return {27'b0, bus.o_action_ack, bus.o_desc_wr, bus.ov_desc_port, bus.ov_desc_data,
                bus.o_bufid_cnt_wr, bus.ov_bufid, bus.ov_bufid_cnt, bus.o_bufid_free_wr};
    endfunction

    function automatic logic [63:0] e_desc(input logic [3:0] p, input logic [15:0] d);
        return {27'b0, 1'b0, 1'b1, p, d, 1'b0, 9'b0, 4'b0, 1'b0};
    endfunction

    function automatic logic [63:0] e_cnt(input logic [8:0] b, input logic [3:0] n);
        return {27'b0, 1'b0, 1'b0, 4'b0, 16'b0, 1'b1, b, n, 1'b0};
    endfunction

    function automatic logic [63:0] e_free(input logic [8:0] b);
        return {27'b0, 1'b0, 1'b0, 4'b0, 16'b0, 1'b0, b, 4'b0, 1'b1};
    endfunction

    localparam logic [63:0] E_ACK  = 64'h1 << 36;
    localparam logic [63:0] E_NONE = 64'h0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic [8:0] outport, input logic hit, input logic [2:0] ptype,
                        input logic [3:0] inport, input logic [8:0] bufid);
        bus.i_action_req  = 1'b1;
        bus.iv_outport    = outport;
        bus.i_entry_hit   = hit;
        bus.iv_pkt_type   = ptype;
        bus.iv_pkt_inport = inport;
        bus.iv_pkt_bufid  = bufid;
    endtask

    initial begin
        logic [3:0] ports [8];
        ports = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_action_req  = 1'b0;
        bus.iv_outport    = '0;
        bus.i_entry_hit   = 1'b0;
        bus.iv_pkt_type   = '0;
        bus.iv_pkt_inport = '0;
        bus.iv_pkt_bufid  = '0;
        bus.iv_queue_full = '0;
        repeat (3) cyc();
        chk("reset_strobes", obs(), E_NONE);
        chk("reset_counters", {32'b0, bus.ov_drop_cnt, bus.ov_flood_cnt}, 64'h0);
        rst_n = 1'b1;
        cyc();
        chk("idle_strobes", obs(), E_NONE);

        // Single-port hit
        send(9'h004, 1'b1, 3'd6, 4'd1, 9'h05A);
        cyc(); chk("t1_c0", obs(), E_NONE);
        cyc(); chk("t1_cnt", obs(), e_cnt(9'h05A, 4'd1));
        cyc(); chk("t1_desc", obs(), e_desc(4'd2, 16'hC25A));
        cyc(); chk("t1_ack", obs(), E_ACK);
        bus.i_action_req = 1'b0;
        cyc(); chk("t1_idle", obs(), E_NONE);

        // Flood with source pruning; fields change while busy and must be ignored
        send(9'h1FD, 1'b0, 3'd3, 4'd1, 9'h1FF);
        cyc(); chk("t2_c0", obs(), E_NONE);
        bus.iv_outport   = 9'h000;
        bus.iv_pkt_bufid = 9'h000;
        cyc(); chk("t2_cnt", obs(), e_cnt(9'h1FF, 4'd8));
        chk("t2_flood", {48'b0, bus.ov_flood_cnt}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(); chk($sformatf("t2_desc%0d", i), obs(), e_desc(ports[i], 16'h63FF));
        end
        cyc(); chk("t2_ack", obs(), E_ACK);
        bus.i_action_req = 1'b0;
        cyc();

        // Pruned to zero ports: free and drop
        send(9'h008, 1'b1, 3'd0, 4'd3, 9'h123);
        cyc(); chk("t3_c0", obs(), E_NONE);
        cyc(); chk("t3_free", obs(), e_free(9'h123));
        cyc(); chk("t3_ack", obs(), E_ACK);
        bus.i_action_req = 1'b0;
        chk("t3_counters", {32'b0, bus.ov_drop_cnt, bus.ov_flood_cnt}, {32'b0, 16'd1, 16'd1});
        cyc();

        // Queue-full stall on port 1 for three write decisions
        send(9'h006, 1'b1, 3'd1, 4'd0, 9'h0AA);
        cyc(); chk("t4_c0", obs(), E_NONE);
        cyc(); chk("t4_cnt", obs(), e_cnt(9'h0AA, 4'd2));
        bus.iv_queue_full = 9'h002;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk($sformatf("t4_stall%0d", i), obs(), E_NONE);
        end
        bus.iv_queue_full = 9'h000;
        cyc(); chk("t4_desc1", obs(), e_desc(4'd1, 16'h20AA));
        cyc(); chk("t4_desc2", obs(), e_desc(4'd2, 16'h20AA));
        cyc(); chk("t4_ack", obs(), E_ACK);
        bus.i_action_req = 1'b0;
        cyc();

        // Reset during a 5-port flood dispatch
        send(9'h01F, 1'b0, 3'd2, 4'd9, 9'h042);
        cyc(); chk("t5_c0", obs(), E_NONE);
        cyc(); chk("t5_cnt", obs(), e_cnt(9'h042, 4'd5));
        cyc(); chk("t5_desc0", obs(), e_desc(4'd0, 16'h5242));
        cyc(); chk("t5_desc1", obs(), e_desc(4'd1, 16'h5242));
        rst_n = 1'b0;
        bus.i_action_req = 1'b0;
        #1;
        chk("t5_rst_strobes", obs(), E_NONE);
        chk("t5_rst_counters", {32'b0, bus.ov_drop_cnt, bus.ov_flood_cnt}, 64'h0);
        cyc(); chk("t5_rst_hold0", obs(), E_NONE);
        cyc(); chk("t5_rst_hold1", obs(), E_NONE);
        rst_n = 1'b1;
        cyc(); chk("t5_post_idle", obs(), E_NONE);
        send(9'h100, 1'b1, 3'd7, 4'd8, 9'h1FF);
        cyc(); chk("t5b_c0", obs(), E_NONE);
        cyc(); chk("t5b_cnt", obs(), e_cnt(9'h1FF, 4'd1));
        cyc(); chk("t5b_desc", obs(), e_desc(4'd8, 16'hF1FF));
        cyc(); chk("t5b_ack", obs(), E_ACK);
        bus.i_action_req = 1'b0;
        chk("t5b_counters", {32'b0, bus.ov_drop_cnt, bus.ov_flood_cnt}, 64'h0);
        cyc();

        // Drop counter saturation, preloaded just below the top
        force dut.drop_cnt = 16'hFFFE;
        #1;
        release dut.drop_cnt;
        for (int k = 0; k < 2; k++) begin
            send(9'h000, 1'b1, 3'd0, 4'd0, 9'h011);
            cyc();
            cyc(); chk($sformatf("t6_free%0d", k), obs(), e_free(9'h011));
            chk($sformatf("t6_drop%0d", k), {48'b0, bus.ov_drop_cnt}, 64'hFFFF);
            cyc(); chk($sformatf("t6_ack%0d", k), obs(), E_ACK);
            bus.i_action_req = 1'b0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
